pc_stack_unit: RTL and testbench

Program-counter and return-address stack stage that sits directly downstream of the single-cycle controller. It consumes the controller's `pcEn`, `jmp`, `branch`, `ret`, `push` and `pop` strobes plus the jump and branch operand fields of the current instruction. It produces the next fetch address for instruction memory. CALL return addresses are held in an internal LIFO, with sticky overflow and underflow error flags.

---
 rtl/pc_stack_unit.sv | 101 ++++++++++
 tb/tb_pc_stack_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pc_stack_unit.sv
// PC register and return-address stack fed by the controller strobes.
// Produces the next fetch address and tracks stack misuse.
module pc_stack_unit #(
    parameter int ADDR_W = 12,
    parameter int OFF_W  = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pcEn,
    input  logic                     jmp,
    input  logic                     branch,
    input  logic                     ret,
    input  logic                     push,
    input  logic                     pop,
    input  logic [ADDR_W-1:0]        jmpAddr,
    input  logic [OFF_W-1:0]         brOffset,
    output logic [ADDR_W-1:0]        pc,
    output logic [$clog2(DEPTH):0]   sp,
    output logic                     stackFull,
    output logic                     stackEmpty,
    output logic                     overflowErr,
    output logic                     underflowErr
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [ADDR_W-1:0] stack [DEPTH];

    logic [ADDR_W-1:0] pcPlus1;
    logic [ADDR_W-1:0] brTarget;
    logic [ADDR_W-1:0] tos;
    logic [ADDR_W-1:0] nextPc;
    logic [IDX_W-1:0]  wrIdx;
    logic [IDX_W-1:0]  tosIdx;
    logic              doCall;
    logic              doRet;
    logic              callOk;
    logic              retOk;
    logic              unusedPop;

    // The decrement is driven by ret alone; pop carries no extra meaning.
    assign unusedPop = pop;

    assign stackFull  = (sp == SP_W'(DEPTH));
    assign stackEmpty = (sp == '0);

    assign pcPlus1  = pc + 1'b1;
    assign brTarget = pcPlus1 + ADDR_W'($signed(brOffset));

    assign wrIdx  = sp[IDX_W-1:0];
    assign tosIdx = IDX_W'(sp - 1'b1);
    assign tos    = stack[tosIdx];

    assign doRet  = pcEn & ret;
    assign doCall = pcEn & jmp & push & ~ret;
    assign callOk = doCall & ~stackFull;
    assign retOk  = doRet & ~stackEmpty;

    always_comb begin
        nextPc = pcPlus1;
        if (ret) begin
            nextPc = stackEmpty ? pcPlus1 : tos;
        end else if (jmp) begin
            nextPc = jmpAddr;
        end else if (branch) begin
            nextPc = brTarget;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= '0;
            sp           <= '0;
            overflowErr  <= 1'b0;
            underflowErr <= 1'b0;
        end else if (pcEn) begin
            pc <= nextPc;
            if (callOk) begin
                sp <= sp + 1'b1;
            end else if (retOk) begin
                sp <= sp - 1'b1;
            end
            if (doCall && stackFull) begin
                overflowErr <= 1'b1;
            end
            if (doRet && stackEmpty) begin
                underflowErr <= 1'b1;
            end
        end
    end

    // Storage is not reset; an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (!rst && callOk) begin
            stack[wrIdx] <= pcPlus1;
        end
    end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit with a queue-based reference model.
// Model state advances on each edge; outputs are compared every cycle.
module tb_pc_stack_unit;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pcEn = 1'b0;
    logic        jmp = 1'b0;
    logic        branch = 1'b0;
    logic        ret = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic [11:0] jmpAddr = '0;
    logic [7:0]  brOffset = '0;
    logic [11:0] pc;
    logic [3:0]  sp;
    logic        stackFull;
    logic        stackEmpty;
    logic        overflowErr;
    logic        underflowErr;

    int nChecks = 0;
    int nFails  = 0;
    bit live    = 0;

    int mpc  = 0;
    bit movf = 0;
    bit munf = 0;
    int stk[$];

    pc_stack_unit #(.ADDR_W(12), .OFF_W(8), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .pcEn(pcEn),
        .jmp(jmp),
        .branch(branch),
        .ret(ret),
        .push(push),
        .pop(pop),
        .jmpAddr(jmpAddr),
        .brOffset(brOffset),
        .pc(pc),
        .sp(sp),
        .stackFull(stackFull),
        .stackEmpty(stackEmpty),
        .overflowErr(overflowErr),
        .underflowErr(underflowErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (live) begin
            chk("pc", pc, mpc);
            chk("sp", sp, stk.size());
            chk("full", stackFull, stk.size() == DEPTH);
            chk("empty", stackEmpty, stk.size() == 0);
            chk("ovf", overflowErr, movf);
            chk("unf", underflowErr, munf);
        end
    end

    task automatic step(input logic r, input logic en, input logic j,
                        input logic b, input logic rt, input logic pu,
                        input logic po, input logic [11:0] a,
                        input logic [7:0] o);
        int p1;
        rst = r; pcEn = en; jmp = j; branch = b;
        ret = rt; push = pu; pop = po;
        jmpAddr = a; brOffset = o;
        @(posedge clk);
        p1 = (mpc + 1) & 'hFFF;
        if (r) begin
            mpc = 0; stk.delete(); movf = 0; munf = 0;
            live = 1;
        end else if (en) begin
            if (rt) begin
                if (stk.size() == 0) begin
                    munf = 1; mpc = p1;
                end else begin
                    mpc = stk.pop_back();
                end
            end else if (j) begin
                if (pu) begin
                    if (stk.size() == DEPTH) movf = 1;
                    else stk.push_back(p1);
                end
                mpc = a;
            end else if (b) begin
                mpc = (p1 + int'($signed(o))) & 'hFFF;
            end else begin
                mpc = p1;
            end
        end
        #1;
    endtask

    task automatic idle();
        step(0, 1, 0, 0, 0, 0, 0, 12'h0, 8'h0);
    endtask

    task automatic call(input logic [11:0] a);
        step(0, 1, 1, 0, 0, 1, 0, a, 8'h0);
    endtask

    task automatic retn();
        step(0, 1, 0, 0, 1, 0, 1, 12'h0, 8'h0);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 12'h0, 8'h0);
        chk("rst_pc", pc, 0);
        chk("rst_sp", sp, 0);
        chk("rst_empty", stackEmpty, 1);
        chk("rst_full", stackFull, 0);

        repeat (4) idle();
        chk("seq_pc4", pc, 4);
        idle();
        step(0, 1, 0, 1, 0, 0, 0, 12'h0, 8'hFC);
        chk("br_back", pc, 2);
        step(0, 1, 1, 0, 0, 0, 0, 12'hFFF, 8'h0);
        step(0, 1, 0, 1, 0, 0, 0, 12'h0, 8'h01);
        chk("br_wrap", pc, 1);

        idle();
        idle();
        call(12'h100);
        chk("call1_pc", pc, 12'h100);
        chk("call1_sp", sp, 1);
        call(12'h200);
        chk("call2_sp", sp, 2);
        retn();
        chk("ret1_pc", pc, 12'h101);
        retn();
        chk("ret2_pc", pc, 4);
        chk("ret2_empty", stackEmpty, 1);

        step(0, 1, 0, 0, 0, 1, 0, 12'h0, 8'h0);
        step(0, 1, 0, 0, 0, 0, 1, 12'h0, 8'h0);
        chk("stray_sp", sp, 0);

        step(0, 1, 1, 0, 0, 0, 0, 12'h040, 8'h0);
        repeat (9) call(12'h040);
        chk("ovf_pc", pc, 12'h040);
        chk("ovf_sp", sp, 8);
        chk("ovf_flag", overflowErr, 1);
        repeat (8) retn();
        chk("unwind_pc", pc, 12'h041);
        retn();
        chk("unf_pc", pc, 12'h042);
        chk("unf_flag", underflowErr, 1);

        repeat (3) step(0, 0, 1, 0, 1, 1, 1, 12'h123, 8'h7F);
        chk("hold_pc", pc, 12'h042);

        call(12'h300);
        step(0, 1, 1, 0, 1, 1, 1, 12'h500, 8'h0);
        chk("prio_pc", pc, 12'h043);
        chk("prio_sp", sp, 0);

        call(12'h600);
        step(1, 1, 1, 0, 0, 1, 0, 12'h700, 8'h0);
        chk("mid_rst_pc", pc, 0);
        chk("mid_rst_ovf", overflowErr, 0);
        idle();
        call(12'h010);
        retn();
        chk("post_rst_pc", pc, 2);

        @(negedge clk);
        live = 0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

endmodule
